// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared key encodings, state enum and key helpers for the safe sequencer
package safe_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROG    = 3'd4,
    LOCKOUT = 3'd5
  } safe_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_key(input logic [3:0] k);
    return is_digit(k) || (k == KEY_STAR) || (k == KEY_HASH);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - turns raw scanner codes into one event per stable press
module key_debouncer
  import safe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] key_value
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [3:0]       prev_code;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;

  // Run length of the current sample value, saturating once it is stable.
  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (key_code == prev_code) begin
      cnt_nxt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code  <= KEY_NONE;
      stable_cnt <= '0;
      armed      <= 1'b1;
      key_event  <= 1'b0;
      key_value  <= KEY_NONE;
    end else begin
      prev_code  <= key_code;
      stable_cnt <= cnt_nxt;
      key_event  <= 1'b0;
      if (cnt_nxt == CNT_MAX) begin
        if (key_code == KEY_NONE) begin
          armed <= 1'b1;
        end else if (armed && is_key(key_code)) begin
          key_event <= 1'b1;
          key_value <= key_code;
          armed     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/code_entry_sequencer.sv
// rtl/code_entry_sequencer.sv - safe code entry, check, lockout and reprogramming FSM
module code_entry_sequencer
  import safe_pkg::*;
#(
  parameter int                      CODE_LEN        = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE    = 16'h1234,
  parameter int                      MAX_FAILS       = 3,
  parameter int                      DEBOUNCE_CYCLES = 4,
  parameter int                      LOCKOUT_CYCLES  = 1000,
  parameter int                      OPEN_TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  output logic       lock,
  output logic       green,
  output logic       blue,
  output logic       lockout,
  output logic [2:0] fail_count,
  output logic       err_pulse,
  output logic       key_event,
  output logic [2:0] state_dbg
);

  localparam int BUF_W   = 4 * CODE_LEN;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int TIMER_W = $clog2((LOCKOUT_CYCLES > OPEN_TIMEOUT) ? LOCKOUT_CYCLES : OPEN_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(CODE_LEN);
  localparam logic [2:0]         MAX_F     = 3'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);

  logic [3:0] key_value;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_code (key_code),
    .key_event(key_event),
    .key_value(key_value)
  );

  safe_state_e        state, nxt_state;
  logic [BUF_W-1:0]   code_buf, nxt_buf;
  logic [BUF_W-1:0]   stored, nxt_stored;
  logic [CNT_W-1:0]   digit_cnt, nxt_cnt;
  logic [TIMER_W-1:0] timer, nxt_timer;
  logic [2:0]         nxt_fail;
  logic               nxt_err;
  logic               is_dig, is_star, is_hash;

  assign is_dig  = key_event && is_digit(key_value);
  assign is_star = key_event && (key_value == KEY_STAR);
  assign is_hash = key_event && (key_value == KEY_HASH);

  always_comb begin
    nxt_state  = state;
    nxt_buf    = code_buf;
    nxt_cnt    = digit_cnt;
    nxt_stored = stored;
    nxt_fail   = fail_count;
    nxt_err    = 1'b0;
    nxt_timer  = '0;
    case (state)
      LOCKED: begin
        if (is_dig) begin
          nxt_buf   = BUF_W'(key_value);
          nxt_cnt   = CNT_W'(1);
          nxt_state = ENTRY;
        end
      end
      ENTRY: begin
        if (is_dig) begin
          if (digit_cnt < FULL_CNT) begin
            nxt_buf = {code_buf[BUF_W-5:0], key_value};
            nxt_cnt = digit_cnt + 1'b1;
          end
        end else if (is_star) begin
          nxt_buf   = '0;
          nxt_cnt   = '0;
          nxt_state = LOCKED;
        end else if (is_hash) begin
          nxt_state = CHECK;
        end
      end
      CHECK: begin
        nxt_buf = '0;
        nxt_cnt = '0;
        if (digit_cnt == FULL_CNT && code_buf == stored) begin
          nxt_fail  = '0;
          nxt_state = OPEN;
        end else begin
          nxt_err = 1'b1;
          if (fail_count >= MAX_F - 3'd1) begin
            nxt_fail  = MAX_F;
            nxt_state = LOCKOUT;
          end else begin
            nxt_fail  = fail_count + 3'd1;
            nxt_state = LOCKED;
          end
        end
      end
      OPEN: begin
        // Expiry has priority over a key arriving on the same cycle.
        if (timer == OPEN_LAST) begin
          nxt_state = LOCKED;
        end else if (key_event) begin
          if (is_star) begin
            nxt_state = LOCKED;
          end else if (is_hash) begin
            nxt_buf   = '0;
            nxt_cnt   = '0;
            nxt_state = PROG;
          end
        end else begin
          nxt_timer = timer + 1'b1;
        end
      end
      PROG: begin
        if (timer == OPEN_LAST) begin
          nxt_buf   = '0;
          nxt_cnt   = '0;
          nxt_state = LOCKED;
        end else if (key_event) begin
          if (is_dig) begin
            if (digit_cnt < FULL_CNT) begin
              nxt_buf = {code_buf[BUF_W-5:0], key_value};
              nxt_cnt = digit_cnt + 1'b1;
            end
          end else if (is_hash || is_star) begin
            if (is_hash && digit_cnt == FULL_CNT) begin
              nxt_stored = code_buf;
            end else if (is_hash) begin
              nxt_err = 1'b1;
            end
            nxt_buf   = '0;
            nxt_cnt   = '0;
            nxt_state = OPEN;
          end
        end else begin
          nxt_timer = timer + 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          nxt_fail  = '0;
          nxt_state = LOCKED;
        end else begin
          nxt_timer = timer + 1'b1;
        end
      end
      default: begin
        nxt_state = LOCKED;
      end
    endcase
    if (nxt_state != state) begin
      nxt_timer = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      code_buf   <= '0;
      digit_cnt  <= '0;
      stored     <= DEFAULT_CODE;
      timer      <= '0;
      fail_count <= '0;
      err_pulse  <= 1'b0;
      lock       <= 1'b1;
      green      <= 1'b0;
      blue       <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state      <= nxt_state;
      code_buf   <= nxt_buf;
      digit_cnt  <= nxt_cnt;
      stored     <= nxt_stored;
      timer      <= nxt_timer;
      fail_count <= nxt_fail;
      err_pulse  <= nxt_err;
      lock       <= !(nxt_state == OPEN || nxt_state == PROG);
      green      <= (nxt_state == OPEN || nxt_state == PROG);
      blue       <= (nxt_state == ENTRY || nxt_state == CHECK || nxt_state == PROG);
      lockout    <= (nxt_state == LOCKOUT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// tb/tb_code_entry_sequencer.sv - directed self-checking bench for code_entry_sequencer
module tb_code_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_code = 4'hF;
  logic       lock, green, blue, lockout, err_pulse, key_event;
  logic [2:0] fail_count, state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_cnt  = 0;
  int err_cnt = 0;
  logic saw_check = 1'b0;

  code_entry_sequencer #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAILS      (3),
    .DEBOUNCE_CYCLES(2),
    .LOCKOUT_CYCLES (20),
    .OPEN_TIMEOUT   (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .lock      (lock),
    .green     (green),
    .blue      (blue),
    .lockout   (lockout),
    .fail_count(fail_count),
    .err_pulse (err_pulse),
    .key_event (key_event),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_event) ev_cnt <= ev_cnt + 1;
    if (err_pulse) err_cnt <= err_cnt + 1;
    if (state_dbg == 3'd2) saw_check <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code = k;
    repeat (4) tick();
    key_code = 4'hF;
    repeat (4) tick();
  endtask

  task automatic enter_keys(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) press(seq[4*(n-1-i) +: 4]);
  endtask

  task automatic do_reset();
    key_code = 4'hF;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({state_dbg, lock, green, blue, lockout, fail_count, err_pulse, key_event} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_outputs got state=%0d lock=%b green=%b blue=%b lockout=%b fails=%0d err=%b ev=%b want 0 1 0 0 0 0 0 0",
               state_dbg, lock, green, blue, lockout, fail_count, err_pulse, key_event);
      n_fail++;
    end
  endtask

  task automatic test_open_default();
    int e0;
    e0 = err_cnt;
    saw_check = 1'b0;
    press(4'h1);
    n_tests++;
    if ({state_dbg, blue, lock} !== {3'd1, 1'b1, 1'b1}) begin
      $display("FAIL entry_state got state=%0d blue=%b lock=%b want 1 1 1", state_dbg, blue, lock);
      n_fail++;
    end
    enter_keys(32'h0000_234B, 4);
    n_tests++;
    if ({state_dbg, lock, green, blue, fail_count} !== {3'd3, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      $display("FAIL open_default got state=%0d lock=%b green=%b blue=%b fails=%0d want 3 0 1 0 0",
               state_dbg, lock, green, blue, fail_count);
      n_fail++;
    end
    n_tests++;
    if (saw_check !== 1'b1 || err_cnt != e0) begin
      $display("FAIL open_check_path got saw_check=%b err_delta=%0d want 1 0", saw_check, err_cnt - e0);
      n_fail++;
    end
  endtask

  task automatic test_debounce();
    int e0;
    do_reset();
    e0 = ev_cnt;
    key_code = 4'h5;
    repeat (30) tick();
    key_code = 4'hF;
    repeat (4) tick();
    n_tests++;
    if (ev_cnt - e0 != 1) begin
      $display("FAIL debounce_long_hold got events=%0d want 1", ev_cnt - e0);
      n_fail++;
    end
    e0 = ev_cnt;
    key_code = 4'h5;
    tick();
    key_code = 4'hF;
    repeat (4) tick();
    key_code = 4'hC;
    repeat (6) tick();
    key_code = 4'hF;
    repeat (4) tick();
    n_tests++;
    if (ev_cnt - e0 != 0) begin
      $display("FAIL debounce_glitch_undef got events=%0d want 0", ev_cnt - e0);
      n_fail++;
    end
  endtask

  task automatic test_lockout();
    int e0;
    do_reset();
    for (int a = 1; a <= 3; a++) begin
      e0 = err_cnt;
      enter_keys(32'h0001_235B, 5);
      n_tests++;
      if (err_cnt - e0 != 1 || fail_count !== 3'(a)) begin
        $display("FAIL wrong_attempt_%0d got err_delta=%0d fails=%0d want 1 %0d", a, err_cnt - e0, fail_count, a);
        n_fail++;
      end
    end
    n_tests++;
    if ({state_dbg, lockout, lock, green} !== {3'd5, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL lockout_entered got state=%0d lockout=%b lock=%b green=%b want 5 1 1 0", state_dbg, lockout, lock, green);
      n_fail++;
    end
    press(4'h1);
    n_tests++;
    if ({state_dbg, lockout, blue} !== {3'd5, 1'b1, 1'b0}) begin
      $display("FAIL lockout_ignores_keys got state=%0d lockout=%b blue=%b want 5 1 0", state_dbg, lockout, blue);
      n_fail++;
    end
    repeat (14) tick();
    n_tests++;
    if ({state_dbg, lockout, fail_count, lock} !== {3'd0, 1'b0, 3'd0, 1'b1}) begin
      $display("FAIL lockout_expired got state=%0d lockout=%b fails=%0d lock=%b want 0 0 0 1", state_dbg, lockout, fail_count, lock);
      n_fail++;
    end
  endtask

  task automatic test_program();
    int e0;
    do_reset();
    enter_keys(32'h0001_234B, 5);
    press(4'hB);
    n_tests++;
    if ({state_dbg, lock, green, blue} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
      $display("FAIL prog_entered got state=%0d lock=%b green=%b blue=%b want 4 0 1 1", state_dbg, lock, green, blue);
      n_fail++;
    end
    enter_keys(32'h0009_876B, 5);
    n_tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL prog_store_back_open got state=%0d want 3", state_dbg);
      n_fail++;
    end
    press(4'hA);
    e0 = err_cnt;
    enter_keys(32'h0001_234B, 5);
    n_tests++;
    if ({state_dbg, fail_count} !== {3'd0, 3'd1} || err_cnt - e0 != 1) begin
      $display("FAIL old_code_rejected got state=%0d fails=%0d err_delta=%0d want 0 1 1", state_dbg, fail_count, err_cnt - e0);
      n_fail++;
    end
    enter_keys(32'h0009_876B, 5);
    n_tests++;
    if ({state_dbg, green, fail_count} !== {3'd3, 1'b1, 3'd0}) begin
      $display("FAIL new_code_opens got state=%0d green=%b fails=%0d want 3 1 0", state_dbg, green, fail_count);
      n_fail++;
    end
  endtask

  task automatic test_short_prog_timeout();
    int e0;
    e0 = err_cnt;
    enter_keys(32'h0000_B98B, 4);
    n_tests++;
    if (state_dbg !== 3'd3 || err_cnt - e0 != 1) begin
      $display("FAIL short_prog_rejected got state=%0d err_delta=%0d want 3 1", state_dbg, err_cnt - e0);
      n_fail++;
    end
    repeat (44) tick();
    n_tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL open_before_timeout got state=%0d want 3", state_dbg);
      n_fail++;
    end
    tick();
    n_tests++;
    if ({state_dbg, lock, green} !== {3'd0, 1'b1, 1'b0}) begin
      $display("FAIL open_timeout got state=%0d lock=%b green=%b want 0 1 0", state_dbg, lock, green);
      n_fail++;
    end
    enter_keys(32'h0009_876B, 5);
    n_tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL stored_kept_after_short got state=%0d want 3", state_dbg);
      n_fail++;
    end
  endtask

  task automatic test_mid_reset_and_entry();
    do_reset();
    enter_keys(32'h0001_234B, 5);
    enter_keys(32'h0000_00B9, 2);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({state_dbg, lock, green, blue, lockout, fail_count, err_pulse, key_event} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL async_reset_mid_prog got state=%0d lock=%b green=%b blue=%b want 0 1 0 0", state_dbg, lock, green, blue);
      n_fail++;
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    enter_keys(32'h0001_234B, 5);
    n_tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL reopen_after_reset got state=%0d want 3", state_dbg);
      n_fail++;
    end
    press(4'hA);
    enter_keys(32'h12A1_234B, 8);
    n_tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL star_clears_entry got state=%0d want 3", state_dbg);
      n_fail++;
    end
    press(4'hA);
    enter_keys(32'h0123_45B0 >> 4, 6);
    n_tests++;
    if ({state_dbg, fail_count} !== {3'd3, 3'd0}) begin
      $display("FAIL extra_digit_ignored got state=%0d fails=%0d want 3 0", state_dbg, fail_count);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_open_default();
    test_debounce();
    test_lockout();
    test_program();
    test_short_prog_timeout();
    test_mid_reset_and_entry();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry_sequencer.md
Name: code_entry_sequencer

Overview:
Sequences the safe. It takes raw 4-bit key codes from the keypad scanner and debounces them into single press events. It collects a fixed-length code, checks it against a stored code, and drives lock/green/blue. It also enforces a lockout after repeated failures and lets the user program a new code while the safe is open. It sits between the keypad scanner's data output and the top-level lock/LED pins, replacing direct scanner-to-control wiring.

Parameters:
CODE_LEN, 4, digits per code; buffer width is 4*CODE_LEN.
DEFAULT_CODE, 16'h1234, code loaded at reset; first-entered digit is in the MSB nibble.
MAX_FAILS, 3, consecutive wrong attempts that trigger LOCKOUT (range 1..7).
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a press or a release.
LOCKOUT_CYCLES, 1000, duration of LOCKOUT.
OPEN_TIMEOUT, 5000, cycles in OPEN with no key event before auto-relock.

Ports:
clk  input  1  system clock, single domain
rst_n  input  1  asynchronous active-low reset
key_code  input  4  raw scanner code: 0-9 digits, 4'hA '*', 4'hB '#', 4'hF no key, others ignored
lock  output  1  1 = bolt engaged
green  output  1  1 = safe open
blue  output  1  1 = entry or programming in progress
lockout  output  1  1 while in LOCKOUT
fail_count  output  3  consecutive failed attempts
err_pulse  output  1  one-cycle pulse on a rejected code or rejected program
key_event  output  1  one-cycle pulse when a debounced press is accepted
state_dbg  output  3  current FSM state encoding

Behaviour:
- Reset (async, rst_n=0): state=LOCKED, lock=1, green=0, blue=0, lockout=0, fail_count=0, err_pulse=0, key_event=0, digit buffer=0, digit count=0, stored code=DEFAULT_CODE, timer=0. A programmed code is not retained across reset.
- Debounce:
  - A press is accepted when key_code is one non-4'hF value for DEBOUNCE_CYCLES consecutive samples.
  - key_event pulses on the cycle the count reaches DEBOUNCE_CYCLES. Exactly one event per hold.
  - The debouncer re-arms only after 4'hF is stable for DEBOUNCE_CYCLES.
  - Undefined codes (4'hC-4'hE) never generate an event.
- The FSM consumes a key event on the edge after key_event. All outputs are decoded from registered state; there is no combinational path from key_code.
- States:
  - LOCKED (0): lock=1, green=0, blue=0.
    - Digit: buffer={0...,d}, count=1 → ENTRY.
    - '*' / '#': ignored.
  - ENTRY (1): blue=1.
    - Digit: if count<CODE_LEN, shift left one nibble and count++. Extra digits beyond CODE_LEN are ignored.
    - '*': clear buffer and count → LOCKED.
    - '#' → CHECK.
  - CHECK (2), one cycle:
    - Match (count==CODE_LEN and buffer==stored): fail_count=0 → OPEN.
    - Otherwise: err_pulse=1 and fail_count++. If the new fail_count==MAX_FAILS → LOCKOUT, else → LOCKED. Buffer is cleared in either case.
  - OPEN (3): lock=0, green=1. Timer counts from 0 and reloads on every key event.
    - '*' → LOCKED.
    - '#' → PROG with buffer and count cleared.
    - Digits: ignored apart from the timer reload.
    - Timer reaching OPEN_TIMEOUT-1 → LOCKED.
  - PROG (4): lock=0, green=1, blue=1.
    - Digits: shift in as in ENTRY.
    - '#' with count==CODE_LEN: stored=buffer → OPEN.
    - '#' with count!=CODE_LEN: err_pulse=1, stored code unchanged → OPEN.
    - '*': abort → OPEN.
    - The OPEN_TIMEOUT rule applies here too (→ LOCKED, nothing stored).
  - LOCKOUT (5): lock=1, green=0, blue=0, lockout=1.
    - All key events are discarded.
    - After LOCKOUT_CYCLES cycles: fail_count=0 → LOCKED.
- Simultaneous events: when timer expiry and a key event fall on the same cycle, expiry wins and the key is discarded.
- Timer: width is clog2(max(LOCKOUT_CYCLES, OPEN_TIMEOUT))+1. It clears on every state change.
- Saturation: fail_count never exceeds MAX_FAILS.
- Mid-operation reset: returns immediately to reset values from any state.

Decomposition:
- Package safe_pkg holds:
  - key encodings: KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_NONE=4'hF;
  - the state enum: LOCKED, ENTRY, CHECK, OPEN, PROG, LOCKOUT;
  - an is_digit helper function.
- One sub-module, key_debouncer (clk, rst_n, key_code → key_event, key_value[3:0]), instantiated once.
- FSM, buffer, counters and timer stay in code_entry_sequencer.

Test Plan:
Bench parameters: DEBOUNCE=2, LOCKOUT=20, OPEN_TIMEOUT=50, defaults otherwise.
1. Hold 1,2,3,4,# (each 4 cycles, 4'hF gap of 4) → CHECK then OPEN; lock=0, green=1, fail_count=0, no err_pulse.
2. Hold key 5 for 30 cycles → exactly one key_event. Glitch 5 for 1 cycle between 4'hF → no event.
3. Enter 1,2,3,5,# three times → err_pulse each time, fail_count 1,2,3. LOCKOUT asserted; keys ignored for 20 cycles; then LOCKED with fail_count=0.
4. Open, then #,9,8,7,6,# → stored=16'h9876. Relock with '*'. 1,2,3,4,# fails; 9,8,7,6,# opens.
5. In PROG enter 9,8,# → err_pulse, stored unchanged, state OPEN. Then idle 50 cycles → LOCKED, lock=1.
6. Assert rst_n=0 mid-PROG → outputs at reset values immediately; 1,2,3,4,# opens again. Also: 1,2,*,1,2,3,4,# opens, and 1,2,3,4,5,# opens (extra digit ignored).
